serial_exp_sub_ctrl: RTL and testbench

Bit-serial sequencer that time-shares a single external one-bit full-adder cell to compute the magnitude of an exponent difference |a − b| and the flag a < b. It sits in front of the half-precision adder/subtractor's alignment stage, where the difference becomes the mantissa shift amount and a_lt_b selects the operand swap. It trades latency for area: one full-adder cell serves the whole word, and the controller owns all operand shifting, carry storage, sequencing and the start/done handshake.

---
 rtl/serial_exp_sub_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_exp_sub_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_exp_sub_ctrl.sv
// Bit-serial |a - b| and a<b sequencer driving one external full-adder cell.
// SUB forms a + ~b + 1 LSB first; a final borrow triggers a NEG pass (0 + ~r + 1).
module serial_exp_sub_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             a_lt_b_o,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_s_i,
    input  logic             fa_cout_i
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d, breg_q, breg_d, rreg_q, rreg_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d, lt_q, lt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rnext;

    assign rnext = {fa_s_i, rreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            rreg_q  <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            lt_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            rreg_q  <= rreg_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            lt_q    <= lt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        rreg_d   = rreg_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        lt_d     = lt_q;
        cnt_d    = cnt_q;
        fa_a_o   = 1'b0;
        fa_b_o   = 1'b0;
        fa_cin_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    areg_d  = a_i;
                    breg_d  = b_i;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                fa_a_o   = areg_q[0];
                fa_b_o   = ~breg_q[0];
                fa_cin_o = carry_q;
                carry_d  = fa_cout_i;
                rreg_d   = rnext;
                areg_d   = areg_q >> 1;
                breg_d   = breg_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // carry-out of 1 means no borrow: a >= b
                    if (fa_cout_i) begin
                        diff_d  = rnext;
                        lt_d    = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        carry_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_NEG;
                    end
                end
            end
            S_NEG: begin
                fa_a_o   = 1'b0;
                fa_b_o   = ~rreg_q[0];
                fa_cin_o = carry_q;
                carry_d  = fa_cout_i;
                rreg_d   = rnext;
                cnt_d    = cnt_q + 1'b1;
                // a_lt_b is committed together with diff so outputs never change mid-operation
                if (cnt_q == LAST) begin
                    diff_d  = rnext;
                    lt_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign diff_o   = diff_q;
    assign a_lt_b_o = lt_q;
endmodule

// File: tb/tb_serial_exp_sub_ctrl.sv
// Bench for serial_exp_sub_ctrl: models the external full-adder and checks
// results and latencies against a plain-arithmetic reference.
module tb_serial_exp_sub_ctrl;
    localparam int W = 5;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, a_lt_b, fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic [W-1:0] diff;

    int n_vec = 0, n_err = 0;

    serial_exp_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .diff_o(diff), .a_lt_b_o(a_lt_b),
        .fa_a_o(fa_a), .fa_b_o(fa_b), .fa_cin_o(fa_cin),
        .fa_s_i(fa_s), .fa_cout_i(fa_cout)
    );

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    always #5 clk = ~clk;

    function automatic int ref_lat(input int x, input int y);
        return (x >= y) ? W + 1 : 2 * W + 1;
    endfunction

    function automatic int ref_diff(input int x, input int y);
        return (x >= y) ? x - y : y - x;
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge following done.
    task automatic run_op(input int x, input int y, output int lat, output logic [W-1:0] d,
                          output logic lt, output int busy_lo, output logic [2:0] fa1,
                          output logic [2:0] fa_dn);
        a = W'(x); b = W'(y); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        fa1 = {fa_a, fa_b, fa_cin};
        lat = 0; busy_lo = 0; d = '0; lt = 1'b0; fa_dn = 3'b111;
        for (int c = 1; c <= 4 * W; c++) begin
            if (!busy) busy_lo++;
            if (done) begin
                lat = c; d = diff; lt = a_lt_b; fa_dn = {fa_a, fa_b, fa_cin};
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if ({busy, done, diff, a_lt_b} !== '0) begin
            n_err++; $display("FAIL reset_outputs got %b want 0", {busy, done, diff, a_lt_b});
        end
        n_vec++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            n_err++; $display("FAIL reset_fa got %b want 000", {fa_a, fa_b, fa_cin});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, blo; logic [W-1:0] d; logic lt; logic [2:0] f1, fd;
        run_op(20, 13, lat, d, lt, blo, f1, fd);
        n_vec++; if (f1 !== 3'b001) begin n_err++; $display("FAIL basic_first_fa got %b want 001", f1); end
        n_vec++; if (lat != 6) begin n_err++; $display("FAIL basic_latency got %0d want 6", lat); end
        n_vec++; if (d !== 5'd7) begin n_err++; $display("FAIL basic_diff got %0d want 7", d); end
        n_vec++; if (lt !== 1'b0) begin n_err++; $display("FAIL basic_lt got %b want 0", lt); end
        n_vec++; if (blo != 0) begin n_err++; $display("FAIL basic_busy got %0d low cycles want 0", blo); end
        n_vec++; if (fd !== 3'b000) begin n_err++; $display("FAIL basic_done_fa got %b want 000", fd); end
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_err++; $display("FAIL basic_after_done got done/busy %b want 00", {done, busy});
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 20; i++) begin
            n_vec++;
            if ({diff, a_lt_b, fa_a, fa_b, fa_cin, done, busy} !== {5'd7, 6'b0}) begin
                n_err++;
                $display("FAIL hold cyc %0d got diff=%0d lt=%b fa=%b done=%b busy=%b want 7/0/000/0/0",
                         i, diff, a_lt_b, {fa_a, fa_b, fa_cin}, done, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_neg();
        int lat, blo; logic [W-1:0] d; logic lt; logic [2:0] f1, fd;
        run_op(13, 20, lat, d, lt, blo, f1, fd);
        n_vec++; if (lat != 11) begin n_err++; $display("FAIL neg_latency got %0d want 11", lat); end
        n_vec++; if (d !== 5'd7) begin n_err++; $display("FAIL neg_diff got %0d want 7", d); end
        n_vec++; if (lt !== 1'b1) begin n_err++; $display("FAIL neg_lt got %b want 1", lt); end
        n_vec++; if (blo != 0) begin n_err++; $display("FAIL neg_busy got %0d low cycles want 0", blo); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL neg_busy_fall got %b want 0", busy); end
    endtask

    task automatic test_extremes();
        int xs[5] = '{0, 31, 17, 31, 0};
        int ys[5] = '{31, 0, 17, 31, 0};
        int lat, blo; logic [W-1:0] d; logic lt; logic [2:0] f1, fd;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], ys[i], lat, d, lt, blo, f1, fd);
            n_vec++;
            if (d !== W'(ref_diff(xs[i], ys[i])) || lt !== (xs[i] < ys[i]) || lat != ref_lat(xs[i], ys[i])) begin
                n_err++;
                $display("FAIL extreme a=%0d b=%0d got diff=%0d lt=%b lat=%0d want %0d/%0b/%0d",
                         xs[i], ys[i], d, lt, lat, ref_diff(xs[i], ys[i]), xs[i] < ys[i], ref_lat(xs[i], ys[i]));
            end
        end
    endtask

    task automatic test_random();
        int x, y, lat, blo; logic [W-1:0] d; logic lt; logic [2:0] f1, fd;
        for (int i = 0; i < 100; i++) begin
            x = int'($urandom_range(31, 0)); y = int'($urandom_range(31, 0));
            run_op(x, y, lat, d, lt, blo, f1, fd);
            n_vec++;
            if (d !== W'(ref_diff(x, y)) || lt !== (x < y) || lat != ref_lat(x, y) || blo != 0) begin
                n_err++;
                $display("FAIL random a=%0d b=%0d got diff=%0d lt=%b lat=%0d busylo=%0d want %0d/%0b/%0d/0",
                         x, y, d, lt, lat, blo, ref_diff(x, y), x < y, ref_lat(x, y));
            end
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    typedef struct { int x; int y; int done_t; } exp_t;

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int next_acc = 0;
        logic exp_done;
        start = 1'b1;
        for (int t = 0; t < 340; t++) begin
            if (t >= 300) start = 1'b0;
            a = W'($urandom); b = W'($urandom);
            if (start && t == next_acc) begin
                e.x = int'(a); e.y = int'(b); e.done_t = t + ref_lat(e.x, e.y) - 1;
                q.push_back(e);
                next_acc = t + ref_lat(e.x, e.y) + 1;
            end
            @(posedge clk); #1;
            exp_done = (q.size() > 0 && q[0].done_t == t);
            n_vec++;
            if (done !== exp_done) begin
                n_err++; $display("FAIL b2b_done t=%0d got %b want %b", t, done, exp_done);
            end
            if (exp_done) begin
                e = q.pop_front();
                n_vec++;
                if (diff !== W'(ref_diff(e.x, e.y)) || a_lt_b !== (e.x < e.y)) begin
                    n_err++;
                    $display("FAIL b2b_result a=%0d b=%0d got diff=%0d lt=%b want %0d/%0b",
                             e.x, e.y, diff, a_lt_b, ref_diff(e.x, e.y), e.x < e.y);
                end
            end
            if (t >= 300 && q.size() == 0) break;
        end
        n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL b2b_drain got %0d pending want 0", q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, blo; logic [W-1:0] d; logic lt; logic [2:0] f1, fd;
        run_op(3, 1, lat, d, lt, blo, f1, fd);
        a = 5'd13; b = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, diff, a_lt_b, fa_a, fa_b, fa_cin} !== '0) begin
            n_err++;
            $display("FAIL midreset_clear got busy=%b done=%b diff=%0d lt=%b fa=%b want all 0",
                     busy, done, diff, a_lt_b, {fa_a, fa_b, fa_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if ({done, busy} !== 2'b00) begin
                n_err++; $display("FAIL midreset_idle cyc %0d got done/busy %b want 00", i, {done, busy});
            end
            @(posedge clk); #1;
        end
        run_op(9, 4, lat, d, lt, blo, f1, fd);
        n_vec++;
        if (d !== 5'd5 || lt !== 1'b0 || lat != 6) begin
            n_err++; $display("FAIL midreset_after got diff=%0d lt=%b lat=%0d want 5/0/6", d, lt, lat);
        end
    endtask

    task automatic test_exhaustive();
        int lat, blo; logic [W-1:0] d; logic lt; logic [2:0] f1, fd;
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
                run_op(x, y, lat, d, lt, blo, f1, fd);
                n_vec++;
                if (d !== W'(ref_diff(x, y)) || lt !== (x < y) || lat != ref_lat(x, y)) begin
                    n_err++;
                    $display("FAIL sweep a=%0d b=%0d got diff=%0d lt=%b lat=%0d want %0d/%0b/%0d",
                             x, y, d, lt, lat, ref_diff(x, y), x < y, ref_lat(x, y));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_neg();
        test_extremes();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
